// File: rtl/mc_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional overflow exception path enabled by defining OVERFLOW_EXC_EN.
module mc_control_fsm #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [2:0] RegDst,
   output logic [1:0] MemToReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       EPCWrite,
   output logic [4:0] state_dbg
);

   localparam int unsigned CW = 3;

   typedef enum logic [4:0] {
      FETCH    = 5'd0,
      DECODE   = 5'd1,
      EXEC_R   = 5'd2,
      WB_R     = 5'd3,
      ADDI_EX  = 5'd4,
      ADDI_WB  = 5'd5,
      MEM_ADDR = 5'd6,
      LW_RD    = 5'd7,
      LW_WB    = 5'd8,
      SW_WR    = 5'd9,
      BEQ      = 5'd10,
      JUMP     = 5'd11,
`ifdef OVERFLOW_EXC_EN
      EXC      = 5'd13,
`endif
      JAL_WB   = 5'd12
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [5:0]    op_q;
   logic          mem_last;

   assign mem_last  = (cnt == CW'(MEM_WAIT));
   assign state_dbg = state;

`ifdef OVERFLOW_EXC_EN
   logic [5:0] funct_q;
   logic       ovf_r;
   logic       unused_inputs;

   assign ovf_r         = overflow && (funct_q == 6'h20 || funct_q == 6'h22);
   assign unused_inputs = zero;

   // funct is captured with the opcode so EXEC_R sees the decoded instruction
   always_ff @(posedge clk) begin
      if (reset)
         funct_q <= '0;
      else if (state == DECODE)
         funct_q <= funct;
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{zero, overflow, funct};
`endif

   // state, wait counter and latched opcode
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         cnt   <= '0;
         op_q  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == DECODE)
            op_q <= opcode;
      end
   end

   // next-state and wait counter; the counter is zero on entry to every memory state
   always_comb begin
      state_next = FETCH;
      cnt_next   = '0;
      case (state)
         FETCH: begin
            if (mem_last) begin
               state_next = DECODE;
            end else begin
               state_next = FETCH;
               cnt_next   = cnt + CW'(1);
            end
         end
         DECODE: begin
            case (opcode)
               6'h00:        state_next = EXEC_R;
               6'h08:        state_next = ADDI_EX;
               6'h23, 6'h2b: state_next = MEM_ADDR;
               6'h04:        state_next = BEQ;
               6'h02:        state_next = JUMP;
               6'h03:        state_next = JAL_WB;
               default:      state_next = FETCH;
            endcase
         end
`ifdef OVERFLOW_EXC_EN
         EXEC_R:   state_next = ovf_r ? EXC : WB_R;
         ADDI_EX:  state_next = overflow ? EXC : ADDI_WB;
`else
         EXEC_R:   state_next = WB_R;
         ADDI_EX:  state_next = ADDI_WB;
`endif
         MEM_ADDR: state_next = (op_q == 6'h2b) ? SW_WR : LW_RD;
         LW_RD: begin
            if (mem_last) begin
               state_next = LW_WB;
            end else begin
               state_next = LW_RD;
               cnt_next   = cnt + CW'(1);
            end
         end
         SW_WR: begin
            if (mem_last) begin
               state_next = FETCH;
            end else begin
               state_next = SW_WR;
               cnt_next   = cnt + CW'(1);
            end
         end
         default:  state_next = FETCH;
      endcase
   end

   // Moore output decode, forced idle while reset is high
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'd0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 3'b000;
      MemToReg    = 2'd0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'd0;
      EPCWrite    = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               MemRead = 1'b1;
               if (mem_last) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  ALUSrcB = 2'd1;
               end
            end
            DECODE:  ALUSrcB = 2'd3;
            EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'd2;
            end
            WB_R: begin
               RegWrite = 1'b1;
               RegDst   = 3'b001;
            end
            ADDI_EX, MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'd2;
            end
            ADDI_WB: RegWrite = 1'b1;
            LW_RD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            LW_WB: begin
               RegWrite = 1'b1;
               MemToReg = 2'd1;
            end
            SW_WR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            BEQ: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'd1;
               PCWriteCond = 1'b1;
               PCSource    = 2'd1;
            end
            JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'd2;
            end
            JAL_WB: begin
               RegWrite = 1'b1;
               RegDst   = 3'b011;
               MemToReg = 2'd2;
               PCWrite  = 1'b1;
               PCSource = 2'd2;
            end
`ifdef OVERFLOW_EXC_EN
            EXC: begin
               EPCWrite = 1'b1;
               PCWrite  = 1'b1;
               PCSource = 2'd3;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: per-instruction expected control-word sequences built from the
// instruction's class, compared cycle by cycle under randomized don't-care inputs.
module tb_mc_control_fsm;

   localparam int unsigned MW = 2;
`ifdef OVERFLOW_EXC_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic [1:0] pcsource;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [2:0] regdst;
      logic [1:0] memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       epcwrite;
   } ctl_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       zero, overflow;

   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, EPCWrite;
   logic [1:0] PCSource, MemToReg, ALUSrcB, ALUOp;
   logic [2:0] RegDst;
   logic [4:0] state_dbg;

   logic       PCWrite1, PCWriteCond1, IorD1, MemRead1, MemWrite1, IRWrite1, RegWrite1, ALUSrcA1, EPCWrite1;
   logic [1:0] PCSource1, MemToReg1, ALUSrcB1, ALUOp1;
   logic [2:0] RegDst1;
   logic [4:0] state_dbg1;

   ctl_t got, got1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_WAIT(MW)) u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .EPCWrite(EPCWrite), .state_dbg(state_dbg)
   );

   mc_control_fsm #(.MEM_WAIT(1)) u_dut1 (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
      .PCWrite(PCWrite1), .PCWriteCond(PCWriteCond1), .PCSource(PCSource1), .IorD(IorD1),
      .MemRead(MemRead1), .MemWrite(MemWrite1), .IRWrite(IRWrite1), .RegWrite(RegWrite1),
      .RegDst(RegDst1), .MemToReg(MemToReg1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
      .ALUOp(ALUOp1), .EPCWrite(EPCWrite1), .state_dbg(state_dbg1)
   );

   assign got  = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                  RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, EPCWrite};
   assign got1 = {PCWrite1, PCWriteCond1, PCSource1, IorD1, MemRead1, MemWrite1, IRWrite1, RegWrite1,
                  RegDst1, MemToReg1, ALUSrcA1, ALUSrcB1, ALUOp1, EPCWrite1};

   // drives random don't-care inputs for one cycle
   task automatic drive_random();
      opcode   = 6'($urandom);
      funct    = 6'($urandom);
      overflow = 1'($urandom);
      zero     = 1'($urandom);
   endtask

   task automatic apply_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset = 1'b1;
         drive_random();
      end
   endtask

   // Runs one instruction from the first FETCH cycle; abort_at >= 0 asserts reset on that cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ov_ex,
                            input int abort_at, input string name);
      ctl_t e[$];
      ctl_t c, exc_w, exp_w;
      int   dec_i, ex_i;
      for (int i = 0; i <= int'(MW); i++) begin
         c = '0;
         c.memread = 1'b1;
         if (i == int'(MW)) begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = 2'd1;
         end
         e.push_back(c);
      end
      dec_i = int'(MW) + 1;
      ex_i  = int'(MW) + 2;
      c = '0; c.alusrcb = 2'd3; e.push_back(c);
      exc_w = '0; exc_w.epcwrite = 1'b1; exc_w.pcwrite = 1'b1; exc_w.pcsource = 2'd3;
      case (op)
         6'h00: begin
            c = '0; c.alusrca = 1'b1; c.aluop = 2'd2; e.push_back(c);
            if (EXC_EN && ov_ex && (fn == 6'h20 || fn == 6'h22)) e.push_back(exc_w);
            else begin c = '0; c.regwrite = 1'b1; c.regdst = 3'b001; e.push_back(c); end
         end
         6'h08: begin
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'd2; e.push_back(c);
            if (EXC_EN && ov_ex) e.push_back(exc_w);
            else begin c = '0; c.regwrite = 1'b1; e.push_back(c); end
         end
         6'h23, 6'h2b: begin
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'd2; e.push_back(c);
            for (int i = 0; i <= int'(MW); i++) begin
               c = '0; c.iord = 1'b1;
               if (op == 6'h23) c.memread = 1'b1; else c.memwrite = 1'b1;
               e.push_back(c);
            end
            if (op == 6'h23) begin c = '0; c.regwrite = 1'b1; c.memtoreg = 2'd1; e.push_back(c); end
         end
         6'h04: begin
            c = '0; c.alusrca = 1'b1; c.aluop = 2'd1; c.pcwritecond = 1'b1; c.pcsource = 2'd1;
            e.push_back(c);
         end
         6'h02: begin c = '0; c.pcwrite = 1'b1; c.pcsource = 2'd2; e.push_back(c); end
         6'h03: begin
            c = '0; c.regwrite = 1'b1; c.regdst = 3'b011; c.memtoreg = 2'd2;
            c.pcwrite = 1'b1; c.pcsource = 2'd2; e.push_back(c);
         end
         default: ;
      endcase
      for (int i = 0; i < e.size(); i++) begin
         @(posedge clk); #1;
         reset = (i == abort_at);
         drive_random();
         if (i == dec_i) begin opcode = op; funct = fn; end
         if (i == ex_i) overflow = ov_ex;
         @(negedge clk);
         exp_w = (i == abort_at) ? ctl_t'('0) : e[i];
         n_vec++;
         if (got !== exp_w) begin
            n_err++;
            $display("FAIL %s cycle %0d: ctl got %h expected %h", name, i, got, exp_w);
         end
         if (i == abort_at) break;
      end
   endtask

   task automatic test_reset();
      ctl_t f0, f1;
      f0 = '0; f0.memread = 1'b1;
      f1 = f0; f1.irwrite = 1'b1; f1.pcwrite = 1'b1; f1.alusrcb = 2'd1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         reset = 1'b1;
         drive_random();
         @(negedge clk);
         n_vec++;
         if (got !== ctl_t'('0) || got1 !== ctl_t'('0)) begin
            n_err++;
            $display("FAIL reset_hold cycle %0d: ctl got %h / %h expected 0", i, got, got1);
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         reset = 1'b0;
         drive_random();
         @(negedge clk);
         n_vec++;
         if (got1 !== ((i == 1) ? f1 : f0)) begin
            n_err++;
            $display("FAIL reset_fetch_mw1 cycle %0d: ctl got %h expected %h", i, got1,
                     (i == 1) ? f1 : f0);
         end
      end
   endtask

   task automatic test_directed();
      apply_reset(1);
      run_instr(6'h00, 6'h20, 1'b0, -1, "r_add");
      run_instr(6'h23, 6'h11, 1'b0, -1, "lw");
      run_instr(6'h2b, 6'h00, 1'b0, -1, "sw");
      run_instr(6'h04, 6'h3f, 1'b1, -1, "beq");
      run_instr(6'h02, 6'h20, 1'b0, -1, "j");
      run_instr(6'h03, 6'h22, 1'b0, -1, "jal");
      run_instr(6'h3f, 6'h20, 1'b1, -1, "nop_3f");
   endtask

   task automatic test_overflow();
      run_instr(6'h08, 6'h00, 1'b1, -1, "addi_ovf");
      run_instr(6'h00, 6'h22, 1'b1, -1, "r_sub_ovf");
      run_instr(6'h00, 6'h24, 1'b1, -1, "r_and_ovf_ignored");
      run_instr(6'h08, 6'h00, 1'b0, -1, "addi");
   endtask

   task automatic test_reset_abort();
      run_instr(6'h2b, 6'h00, 1'b0, int'(MW) + 3, "sw_abort");
      run_instr(6'h00, 6'h20, 1'b0, -1, "after_sw_abort");
      run_instr(6'h23, 6'h00, 1'b0, int'(MW) + 4, "lw_abort");
      run_instr(6'h03, 6'h00, 1'b0, -1, "after_lw_abort");
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [8];
      logic [5:0] fns [4];
      logic [5:0] op, fn;
      ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23; ops[3] = 6'h2b;
      ops[4] = 6'h04; ops[5] = 6'h02; ops[6] = 6'h03; ops[7] = 6'h3f;
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h2a;
      for (int k = 0; k < 80; k++) begin
         op = ops[$urandom_range(0, 7)];
         if (op == 6'h3f) op = 6'($urandom_range(9, 63));
         fn = (k % 5 == 4) ? 6'($urandom) : fns[$urandom_range(0, 3)];
         run_instr(op, fn, 1'($urandom), -1, "random");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
      test_reset();
      test_directed();
      test_overflow();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
